bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side DMA engine for the 2-port sync BRAM. On start, fetches LEN words from BASE
//  through the BRAM read port and emits them as a valid/ready byte stream with LAST marking.
//  Sits between the BRAM read port (registered address, 1-cycle read latency) and the
//  stream sinks (UART TX, SPI TX).
// PARAMETERS
//  DATA  8   word width, matching the BRAM DATA
//  ADDR  10  BRAM address width; transfer length is up to 2**ADDR words
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       start-transfer request; sampled only in IDLE
//  base       in   ADDR    first word address; sampled with start
//  len        in   ADDR+1  word count, 0..2**ADDR; sampled with start
//  busy       out  1       high from the cycle after start is accepted until done
//  done       out  1       one-cycle pulse when the transfer completes
//  mem_addr   out  ADDR    to BRAM read-port address (the BRAM registers it internally)
//  mem_read   in   DATA    from BRAM read data; reflects mem_addr of the previous cycle
//  out_data   out  DATA    stream data
//  out_valid  out  1       stream valid
//  out_ready  in   1       stream ready (backpressure)
//  out_last   out  1       high with the final word of the transfer
// BEHAVIOUR
//  - Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0; state=IDLE.
//  - Reset mid-transfer aborts immediately. No done pulse; buffered words are discarded.
//  - States: IDLE -(start & len!=0)-> RUN -(all words issued)-> DRAIN -(last beat taken)-> IDLE.
//    IDLE -(start & len==0)-> IDLE, with done pulsed the next cycle and no beats emitted.
//  - start while busy is ignored, and base/len are not resampled.
//  - mem_addr = read pointer. A fetch is issued in a RUN cycle when
//    (words in skid + fetch in flight) < 2. The pointer then increments modulo 2**ADDR
//    (0x3FF -> 0x000 wrap is legal).
//  - Fetched data is captured from mem_read exactly 1 cycle after issue into a 2-entry skid FIFO.
//    out_data/out_valid come from the FIFO head (registered, no combinational ready->valid path).
//  - Latency: start at edge 0 -> mem_addr=base in cycle 1 -> out_valid in cycle 3.
//  - Throughput: 1 word/clk with out_ready held high.
//  - out_valid is held, and out_data/out_last are stable, until out_valid & out_ready.
//    No word is lost or duplicated under any ready pattern.
//  - out_last = 1 only on the word whose remaining count is 1.
//  - done pulses in the cycle after the out_last handshake; busy drops in the same cycle.
//  - A new start is accepted in the cycle done is high.
// CONFIGURATION
//  BRAM_READER_CSUM_EN defined:
//  - adds output csum [DATA-1:0]: modulo-2**DATA sum of every word handshaken in the current
//    transfer.
//  - csum clears to 0 on accepted start and on reset.
//  - csum is valid and held from the done pulse until the next accepted start.
//  BRAM_READER_CSUM_EN undefined: the port and the adder are absent; all other behaviour is identical.
// TESTING
//  1. Memory [0x10..0x13] = 11,22,33,44; start base=0x10 len=4, ready=1
//     -> out 11,22,33,44 on consecutive cycles; first valid in cycle 3; last on 44;
//     done 1 cycle later.
//  2. Same as 1 with out_ready toggling 1,0,0,1,...
//     -> data stable while stalled; exact sequence and single last; mem_addr never runs >2 ahead.
//  3. base=0x3FE len=4 -> reads 0x3FE,0x3FF,0x000,0x001 in order (wrap).
//  4. start with len=0 -> no out_valid; done pulse the cycle after start; busy stays 0.
//  5. reset asserted 2 beats into a len=8 transfer
//     -> all outputs at reset values next cycle, no done; a following len=2 run is correct.
//  6. CSUM_EN, words 0xF0,0x20,0x01 -> csum=0x11 at done; a second start clears it to 0.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Read-side DMA: fetches len words from base over a 1-cycle-latency BRAM port into a valid/ready stream.
// Optional BRAM_READER_CSUM_EN adds a running modulo-2**DATA checksum output (csum).
module bram_stream_reader #(
  parameter int DATA = 8,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] base,
  input  logic [ADDR:0]   len,
  output logic            busy,
  output logic            done,
  output logic [ADDR-1:0] mem_addr,
  input  logic [DATA-1:0] mem_read,
  output logic [DATA-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last
`ifdef BRAM_READER_CSUM_EN
  ,
  output logic [DATA-1:0] csum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR:0] CNT_ONE = {{ADDR{1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [ADDR:0]   to_issue;
  logic            inflight;
  logic            inflight_last;
  logic [DATA-1:0] buf_data;
  logic            buf_valid;
  logic            buf_last;

  logic            pop;
  logic            accept;
  logic            issue;
  logic [1:0]      occ_after_pop;

  // Occupancy is counted after this cycle's pop so a full-rate stream keeps one fetch per clock.
  always_comb begin
    pop           = out_valid & out_ready;
    accept        = (state == S_IDLE) & start;
    occ_after_pop = 2'(out_valid) + 2'(buf_valid) - 2'(pop);
    issue         = (state == S_RUN) && (to_issue != '0) &&
                    ((occ_after_pop + 2'(inflight)) < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      to_issue      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_last <= (to_issue == CNT_ONE);
        mem_addr      <= mem_addr + 1'b1;
        to_issue      <= to_issue - CNT_ONE;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            mem_addr <= base;
            to_issue <= len;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && (to_issue == CNT_ONE)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && out_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry skid: out_* is the registered head, buf_* the second slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      buf_valid <= 1'b0;
      buf_last  <= 1'b0;
      buf_data  <= '0;
    end else if (pop) begin
      if (buf_valid) begin
        out_data  <= buf_data;
        out_last  <= buf_last;
        out_valid <= 1'b1;
        buf_valid <= inflight;
        if (inflight) begin
          buf_data <= mem_read;
          buf_last <= inflight_last;
        end
      end else begin
        out_valid <= inflight;
        out_last  <= inflight ? inflight_last : 1'b0;
        if (inflight) out_data <= mem_read;
      end
    end else if (inflight) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= mem_read;
        out_last  <= inflight_last;
      end else begin
        buf_valid <= 1'b1;
        buf_data  <= mem_read;
        buf_last  <= inflight_last;
      end
    end
  end

`ifdef BRAM_READER_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model plus queue-based reference of the expected stream.
// Exercises the csum output when BRAM_READER_CSUM_EN is defined.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_read;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef BRAM_READER_CSUM_EN
  logic [7:0]  csum;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  always @(posedge clk) mem_read <= mem[mem_addr];

  bram_stream_reader #(.DATA(8), .ADDR(10)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base(base),
    .len(len),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
`ifdef BRAM_READER_CSUM_EN
    ,
    .csum(csum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer at the current negedge and follows it to the done pulse.
  // mode 0: ready always high, 1: ready 1,0,0 repeating plus ignored starts, 2: random ready.
  task automatic run_xfer(input logic [9:0] b, input logic [10:0] l, input int mode,
                          input bit timing, output logic [7:0] sum);
    logic [7:0] exp_q [$];
    int         cyc, taken, budget;
    bit         got_last, prev_stall, rdy;
    logic [7:0] prev_d;
    logic       prev_l;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[(int'(b) + i) % 1024]);
    sum = 8'h00;
    start = 1'b1; base = b; len = l; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; taken = 0; got_last = 1'b0; prev_stall = 1'b0;
    budget = 4 * int'(l) + 30;
    chk("busy_after_start", busy, 1);
    chk("first_addr", mem_addr, b);
`ifdef BRAM_READER_CSUM_EN
    chk("csum_cleared", csum, 0);
`endif
    while (!got_last && cyc < budget) begin
      chk("done_early", done, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      chk("addr_ahead", 32'((((int'(mem_addr) - int'(b) - taken) & 1023) <= 2)), 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1) begin
        start = (cyc % 5 == 2);
        base  = b + 10'd7;
        len   = 11'd5;
      end
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("beat_data", out_data, exp_q[taken]);
        chk("beat_last", out_last, 32'(taken == int'(l) - 1));
        if (timing) chk("beat_cycle", cyc, taken + 3);
        sum = sum + out_data;
        got_last = (taken == int'(l) - 1);
        taken++;
      end
      prev_stall = out_valid && !rdy;
      prev_d = out_data;
      prev_l = out_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    chk("xfer_timeout", 32'(got_last), 1);
    chk("beat_count", taken, l);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", out_valid, 0);
    chk("last_at_done", out_last, 0);
`ifdef BRAM_READER_CSUM_EN
    chk("csum_at_done", csum, sum);
`endif
  endtask

  logic [7:0] s;
  int         cnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[16'h010] = 8'h11; mem[16'h011] = 8'h22; mem[16'h012] = 8'h33; mem[16'h013] = 8'h44;
    mem[16'h3FE] = 8'hA1; mem[16'h3FF] = 8'hA2; mem[16'h000] = 8'hA3; mem[16'h001] = 8'hA4;
    mem[16'h100] = 8'hF0; mem[16'h101] = 8'h20; mem[16'h102] = 8'h01;

    reset = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: basic, stalled (back-to-back start on done), wrap.
    run_xfer(10'h010, 11'd4, 0, 1'b1, s);
    run_xfer(10'h010, 11'd4, 1, 1'b0, s);
    run_xfer(10'h3FE, 11'd4, 0, 1'b1, s);

    for (int k = 0; k < 5; k++)
      run_xfer(10'($urandom), 11'($urandom_range(1, 40)), 2, 1'b0, s);

    // Zero-length start issued in the done cycle.
    start = 1'b1; base = 10'h055; len = 11'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("len0_quiet_done", done, 0);
      chk("len0_quiet_busy", busy, 0);
      chk("len0_quiet_valid", out_valid, 0);
    end

    // Reset two beats into a len=8 transfer.
    start = 1'b1; base = 10'h050; len = 11'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 2; k++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    chk("pre_reset_beats", cnt, 2);
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_data", out_data, 0);
    chk("abort_addr", mem_addr, 0);
`ifdef BRAM_READER_CSUM_EN
    chk("abort_csum", csum, 0);
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_valid", out_valid, 0);
    end
    run_xfer(10'h060, 11'd2, 2, 1'b0, s);

`ifdef BRAM_READER_CSUM_EN
    run_xfer(10'h100, 11'd3, 2, 1'b0, s);
    chk("csum_value", csum, 8'h11);
    run_xfer(10'h010, 11'd4, 0, 1'b1, s);
`endif

    // Full-depth transfer from a non-zero base.
    run_xfer(10'h200, 11'd1024, 0, 1'b1, s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
